imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Write-side counterpart of the 64-word instruction memory: fills the instruction RAM at run time instead of from a memory file.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Issues one-cycle word writes at byte addresses 0, 4, 8, ...
- Sits between a host byte source (UART/JTAG bridge) and the instruction RAM write port; the core is held off while `busy` is high.

Parameters:
- DEPTH, 64, number of 32-bit words in the target instruction RAM.
- CNT_W, 7, width of the word counter; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  input  1  single system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a load from word 0.
- in_valid  input  1  byte source has a byte on in_data.
- in_data  input  8  stream byte.
- in_last  input  1  qualifies the final byte of the image; sampled with in_valid.
- in_ready  output  1  loader accepts a byte this cycle.
- we  output  1  instruction RAM write strobe, one cycle per word.
- waddr  output  32  byte address of the write; bits [1:0] always 0.
- wdata  output  32  assembled instruction word.
- busy  output  1  load in progress.
- done  output  1  load finished; sticky until next start or reset.
- overflow  output  1  image exceeded DEPTH words; sticky until next start or reset.
- word_count  output  CNT_W  words written in the current load.
- cksum  output  32  running word sum (see Optional Feature).

Behaviour:
- Reset (reset_n low, asynchronous):
  - state = IDLE.
  - All outputs 0, including in_ready, we, waddr, wdata, busy, done, overflow, word_count and cksum.
  - Internal byte index = 0; assembly register = 0.
- States IDLE, LOAD, FLUSH, DONE.
- IDLE:
  - in_ready = 0.
  - start → LOAD; clears done, overflow, word_count, cksum and byte index.
- LOAD:
  - in_ready = 1; busy = 1.
  - A byte is accepted when in_valid && in_ready.
  - Byte k (k = 0..3) goes to assembly bits [8k+7:8k].
- Word completion (4th byte, or in_last on any byte):
  - Completed word, zero-padded above the bytes received, is copied into wdata.
  - waddr = word_count << 2.
  - we = 1 on the following cycle, for exactly one cycle.
  - word_count increments in the same cycle that we is high.
  - Assembly register and byte index clear at acceptance, so a full-rate stream needs no stall.
- in_last:
  - in_last on an accepted byte → FLUSH, regardless of whether a write is pending.
  - in_last with byte index 0 after a completed word cannot occur; in_last always terminates the current byte.
- FLUSH:
  - in_ready = 0.
  - Waits for any pending we cycle to complete, then → DONE.
- DONE:
  - busy = 0, done = 1.
  - start → LOAD (restart clears everything as from IDLE).
- Overflow:
  - A word completes when word_count == DEPTH → no we, overflow = 1, state → FLUSH.
  - Remaining bytes are not consumed.
- Ignored inputs:
  - start while in LOAD/FLUSH is ignored.
  - in_valid outside LOAD is ignored.
- reset_n asserted mid-load aborts immediately; partial words are discarded and never written.
- Latency: accepted 4th byte at edge N → we high during cycle N+1.

Optional Feature:
- Macro: IMEM_LOADER_CKSUM_EN.
- Defined:
  - cksum accumulates the 32-bit wrap-around sum of every wdata value, updated in the cycle we is high.
  - cksum is cleared on start and on reset.
  - Overflowed words are not summed.
- Not defined: cksum is tied to 32'h0 and no adder is built.

Test Plan:
- Reset, then start; stream 13 00 00 00 93 00 10 00 with in_last on the final byte:
  - we pulses twice: (waddr 0x0, wdata 0x00000013) then (0x4, 0x00100093).
  - done = 1, word_count = 2; with CKSUM_EN, cksum = 0x001000A6.
- Stream 6 bytes EF BE AD DE 01 02 with in_last on 02:
  - Writes 0xDEADBEEF at 0x0 and 0x00000201 at 0x4 (zero pad).
- Stream 260 bytes with in_valid held high (DEPTH = 64):
  - 64 writes, last at waddr 0xFC; overflow = 1 on word 65; no write at 0x100; done = 1.
- Start a load, assert reset_n low after 2 bytes:
  - No we pulse; all outputs 0.
  - After reset and a new start, first write lands at waddr 0x0.
- in_valid toggling 1/0 every cycle over 8 bytes:
  - Same 2 words and addresses as the first scenario.
  - in_ready never drops in LOAD.
- Pulse start during LOAD:
  - Ignored; word_count continues.
  - start in DONE clears done and word_count to 0.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream input, RAM write port and status bundle of the instruction memory loader.
// slave = loader side, master = host/bench side.
interface imem_loader_if #(
  parameter int CNT_W = 7
);
  logic             start;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_last;
  logic             in_ready;
  logic             we;
  logic [31:0]      waddr;
  logic [31:0]      wdata;
  logic             busy;
  logic             done;
  logic             overflow;
  logic [CNT_W-1:0] word_count;
  logic [31:0]      cksum;

  modport slave (
    input  start, in_valid, in_data, in_last,
    output in_ready, we, waddr, wdata, busy, done, overflow, word_count, cksum
  );

  modport master (
    output start, in_valid, in_data, in_last,
    input  in_ready, we, waddr, wdata, busy, done, overflow, word_count, cksum
  );
endinterface

// File: rtl/imem_loader.sv
// Run-time instruction RAM filler: packs a little-endian byte stream into 32-bit words.
// Optional running word sum enabled by defining IMEM_LOADER_CKSUM_EN.
module imem_loader #(
  parameter int DEPTH = 64,
  parameter int CNT_W = 7
) (
  input logic            clk,
  input logic            reset_n,
  imem_loader_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam int               PAD_W   = 30 - CNT_W;

  state_t           state_r;
  logic [1:0]       byte_idx_r;
  logic [31:0]      asm_r;
  logic             in_ready_r;
  logic             we_r;
  logic [31:0]      waddr_r;
  logic [31:0]      wdata_r;
  logic             busy_r;
  logic             done_r;
  logic             overflow_r;
  logic [CNT_W-1:0] word_count_r;

  logic             accept_s;
  logic             complete_s;
  logic             write_s;
  logic             restart_s;
  logic [31:0]      word_s;

  // Merge the incoming byte into the partial word; bytes above stay zero.
  always_comb begin
    word_s = asm_r;
    case (byte_idx_r)
      2'd0:    word_s[7:0]   = bus.in_data;
      2'd1:    word_s[15:8]  = bus.in_data;
      2'd2:    word_s[23:16] = bus.in_data;
      2'd3:    word_s[31:24] = bus.in_data;
      default: word_s        = asm_r;
    endcase
  end

  // Handshake and word-completion qualifiers.
  always_comb begin
    accept_s   = bus.in_valid && in_ready_r && (state_r == LOAD);
    complete_s = accept_s && ((byte_idx_r == 2'd3) || bus.in_last);
    write_s    = complete_s && (word_count_r != DEPTH_C);
    restart_s  = bus.start && ((state_r == IDLE) || (state_r == DONE));
  end

  // Load sequencer with registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      byte_idx_r   <= 2'd0;
      asm_r        <= 32'h0;
      in_ready_r   <= 1'b0;
      we_r         <= 1'b0;
      waddr_r      <= 32'h0;
      wdata_r      <= 32'h0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      overflow_r   <= 1'b0;
      word_count_r <= '0;
    end else begin
      we_r <= 1'b0;
      case (state_r)
        IDLE, DONE: begin
          if (restart_s) begin
            state_r      <= LOAD;
            in_ready_r   <= 1'b1;
            busy_r       <= 1'b1;
            done_r       <= 1'b0;
            overflow_r   <= 1'b0;
            word_count_r <= '0;
            byte_idx_r   <= 2'd0;
            asm_r        <= 32'h0;
          end
        end
        LOAD: begin
          if (complete_s) begin
            // Clearing at acceptance lets the next word start on the very next byte.
            asm_r      <= 32'h0;
            byte_idx_r <= 2'd0;
            if (write_s) begin
              we_r         <= 1'b1;
              waddr_r      <= {{PAD_W{1'b0}}, word_count_r, 2'b00};
              wdata_r      <= word_s;
              word_count_r <= word_count_r + CNT_W'(1);
            end else begin
              overflow_r <= 1'b1;
            end
            if (bus.in_last || !write_s) begin
              state_r    <= FLUSH;
              in_ready_r <= 1'b0;
            end
          end else if (accept_s) begin
            asm_r      <= word_s;
            byte_idx_r <= byte_idx_r + 2'd1;
          end
        end
        FLUSH: begin
          // Any pending strobe is already on the bus this cycle.
          state_r <= DONE;
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
        end
        default: begin
          state_r    <= IDLE;
          in_ready_r <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

`ifdef IMEM_LOADER_CKSUM_EN
  logic [31:0] cksum_r;

  // Wrap-around sum of words actually written.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cksum_r <= 32'h0;
    end else if (restart_s) begin
      cksum_r <= 32'h0;
    end else if (write_s) begin
      cksum_r <= cksum_r + word_s;
    end else begin
      cksum_r <= cksum_r;
    end
  end

  assign bus.cksum = cksum_r;
`else
  assign bus.cksum = 32'h0;
`endif

  assign bus.in_ready   = in_ready_r;
  assign bus.we         = we_r;
  assign bus.waddr      = waddr_r;
  assign bus.wdata      = wdata_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.overflow   = overflow_r;
  assign bus.word_count = word_count_r;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a byte-level model queues expected writes, a monitor pops them.
module tb_imem_loader;

  localparam int DEPTH = 64;
  localparam int CNT_W = 7;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  imem_loader_if #(.CNT_W(CNT_W)) bus ();

  imem_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;

  logic [63:0] sb[$];
  int          m_cnt;
  int          m_idx;
  logic [31:0] m_asm;
  logic [31:0] m_ck;
  logic        m_ovf;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_cksum();
`ifdef IMEM_LOADER_CKSUM_EN
    return m_ck;
`else
    return 32'h0;
`endif
  endfunction

  task automatic model_restart();
    m_cnt = 0;
    m_idx = 0;
    m_asm = 32'h0;
    m_ck  = 32'h0;
    m_ovf = 1'b0;
  endtask

  task automatic model_accept(input logic [7:0] b, input logic last);
    m_asm[8*m_idx +: 8] = b;
    if (m_idx == 3 || last) begin
      if (m_cnt == DEPTH) begin
        m_ovf = 1'b1;
      end else begin
        sb.push_back({32'(m_cnt * 4), m_asm});
        m_ck = m_ck + m_asm;
        m_cnt++;
      end
      m_asm = 32'h0;
      m_idx = 0;
    end else begin
      m_idx++;
    end
  endtask

  // Write-port monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (bus.we === 1'b1) begin
      we_cnt++;
      if (sb.size() == 0) begin
        check_eq("unexpected_we", 32'(sb.size()), 32'd1);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        check_eq("waddr", bus.waddr, e[63:32]);
        check_eq("wdata", bus.wdata, e[31:0]);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic last, input logic keep);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    bus.in_last  = last;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      check_eq("accept_timeout", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
    end else begin
      model_accept(b, last);
      @(negedge clk);
      bus.in_last = 1'b0;
      if (!keep) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("done", 32'(bus.done), 32'd1);
    check_eq("busy_done", 32'(bus.busy), 32'd0);
    check_eq("sb_drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_all_zero();
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check_eq("rst_we", 32'(bus.we), 32'd0);
    check_eq("rst_waddr", bus.waddr, 32'h0);
    check_eq("rst_wdata", bus.wdata, 32'h0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_done", 32'(bus.done), 32'd0);
    check_eq("rst_overflow", 32'(bus.overflow), 32'd0);
    check_eq("rst_word_count", 32'(bus.word_count), 32'd0);
    check_eq("rst_cksum", bus.cksum, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] s1[8];
    logic [7:0] s2[6];
    int         we_snap;
    s1 = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    s2 = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h01, 8'h02};
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_last  = 1'b0;
    model_restart();
    repeat (3) @(negedge clk);
    check_all_zero();
    reset_n = 1'b1;
    @(negedge clk);

    // Two-word image, back-to-back bytes.
    model_restart();
    pulse_start();
    check_eq("busy_load", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 8; i++) send_byte(s1[i], i == 7, 1'b1);
    bus.in_valid = 1'b0;
    wait_done();
    check_eq("s1_word_count", 32'(bus.word_count), 32'd2);
    check_eq("s1_cksum", bus.cksum, exp_cksum());
    check_eq("s1_overflow", 32'(bus.overflow), 32'd0);

    // Partial last word is zero padded.
    model_restart();
    pulse_start();
    check_eq("s2_done_cleared", 32'(bus.done), 32'd0);
    for (int i = 0; i < 6; i++) send_byte(s2[i], i == 5, 1'b1);
    bus.in_valid = 1'b0;
    wait_done();
    check_eq("s2_word_count", 32'(bus.word_count), 32'd2);
    check_eq("s2_cksum", bus.cksum, exp_cksum());

    // Overflow: 65 words streamed at full rate into a 64-word RAM.
    model_restart();
    we_snap = we_cnt;
    pulse_start();
    for (int i = 0; i < 260; i++) send_byte(8'((i * 7 + 1) & 255), 1'b0, 1'b1);
    bus.in_valid = 1'b0;
    wait_done();
    check_eq("ovf_flag", 32'(bus.overflow), 32'(m_ovf));
    check_eq("ovf_writes", 32'(we_cnt - we_snap), 32'd64);
    check_eq("ovf_word_count", 32'(bus.word_count), 32'd64);
    check_eq("ovf_in_ready", 32'(bus.in_ready), 32'd0);
    check_eq("ovf_cksum", bus.cksum, exp_cksum());

    // Reset in the middle of a word discards it.
    model_restart();
    pulse_start();
    send_byte(8'hAA, 1'b0, 1'b0);
    send_byte(8'hBB, 1'b0, 1'b0);
    we_snap = we_cnt;
    reset_n = 1'b0;
    #1;
    check_all_zero();
    model_restart();
    repeat (3) @(negedge clk);
    check_eq("rst_no_we", 32'(we_cnt - we_snap), 32'd0);
    reset_n = 1'b1;
    pulse_start();
    send_byte(8'h11, 1'b0, 1'b1);
    send_byte(8'h22, 1'b0, 1'b1);
    send_byte(8'h33, 1'b0, 1'b1);
    send_byte(8'h44, 1'b1, 1'b1);
    bus.in_valid = 1'b0;
    wait_done();
    check_eq("rst_reload_count", 32'(bus.word_count), 32'd1);

    // in_valid toggling every cycle.
    model_restart();
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      check_eq("tog_in_ready", 32'(bus.in_ready), 32'd1);
      send_byte(s1[i], i == 7, 1'b0);
    end
    wait_done();
    check_eq("tog_word_count", 32'(bus.word_count), 32'd2);
    check_eq("tog_cksum", bus.cksum, exp_cksum());

    // start during LOAD is ignored; start in DONE restarts.
    model_restart();
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(8'(8'h50 + i), 1'b0, 1'b1);
    bus.in_valid = 1'b0;
    pulse_start();
    check_eq("ign_start_count", 32'(bus.word_count), 32'd1);
    check_eq("ign_start_busy", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 4; i++) send_byte(8'(8'h60 + i), i == 3, 1'b1);
    bus.in_valid = 1'b0;
    wait_done();
    check_eq("ign_word_count", 32'(bus.word_count), 32'd2);
    model_restart();
    pulse_start();
    check_eq("restart_done", 32'(bus.done), 32'd0);
    check_eq("restart_count", 32'(bus.word_count), 32'd0);
    check_eq("restart_cksum", bus.cksum, 32'h0);
    for (int i = 0; i < 4; i++) send_byte(8'(8'hC0 + i), i == 3, 1'b1);
    bus.in_valid = 1'b0;
    wait_done();
    check_eq("restart_word_count", 32'(bus.word_count), 32'd1);
    check_eq("restart_final_cksum", bus.cksum, exp_cksum());

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
